// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common-bus arbiter: state encoding and default sizing.
// Lives next to the cache definitions so wrappers and arbiter agree on bus width.
package com_bus_arbiter_pkg;

  localparam int DEFAULT_NUM_CORES = 4;
  localparam int DEFAULT_OWNER_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PROC       = 2'd1,
    ST_PROC_SNOOP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/com_bus_arbiter_rr_pick.sv
// rr_priority_pick: combinational pick of the first set request at or above ptr,
// wrapping around; ptr tied to 0 turns it into a fixed lowest-index priority pick.
module rr_priority_pick
  import com_bus_arbiter_pkg::*;
#(
  parameter int N     = DEFAULT_NUM_CORES,
  parameter int IDX_W = DEFAULT_OWNER_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: round-robin processor grants with nested fixed-priority snoop grants
// and bus-wide invalidation/shared aggregation. Optional watchdog: define ARB_TIMEOUT_EN.
module com_bus_arbiter
  import com_bus_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = DEFAULT_NUM_CORES,
  parameter int OWNER_W        = DEFAULT_OWNER_W,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] Com_Bus_Req_proc,
  output logic [NUM_CORES-1:0] Com_Bus_Gnt_proc,
  input  logic [NUM_CORES-1:0] Com_Bus_Req_snoop,
  output logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop,
  input  logic [NUM_CORES-1:0] Invalidation_done,
  input  logic [NUM_CORES-1:0] Shared_local,
  output logic                 All_Invalidation_done,
  output logic                 Shared,
  output logic                 bus_busy,
  output logic [OWNER_W-1:0]   bus_owner,
  output logic                 timeout
);

  if (OWNER_W != $clog2(NUM_CORES)) begin : g_bad_owner_w
    $error("OWNER_W must equal clog2(NUM_CORES)");
  end
  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  arb_state_t           state, state_nxt;
  logic [OWNER_W-1:0]   owner_q, owner_nxt;
  logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_nxt;
  logic [NUM_CORES-1:0] snoop_oh_q, snoop_oh_nxt;
  logic [NUM_CORES-1:0] owner_oh;
  logic [OWNER_W-1:0]   ptr_after_owner;
  logic                 timeout_hit;
  logic [NUM_CORES-1:0] blocked_q;

  logic [NUM_CORES-1:0] proc_oh, snoop_pick_oh;
  logic [OWNER_W-1:0]   proc_idx, snoop_idx;
  logic                 proc_valid, snoop_valid;
  logic                 unused_pick;

  assign owner_oh        = NUM_CORES'(1) << owner_q;
  assign ptr_after_owner = (owner_q == OWNER_W'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;
  assign unused_pick     = ^{proc_oh, snoop_idx};

  rr_priority_pick #(.N(NUM_CORES), .IDX_W(OWNER_W)) u_proc_pick (
    .req    (Com_Bus_Req_proc & ~blocked_q),
    .ptr    (rr_ptr_q),
    .onehot (proc_oh),
    .idx    (proc_idx),
    .valid  (proc_valid)
  );

  // The owner never snoops itself, so its snoop request is masked out of the pick.
  rr_priority_pick #(.N(NUM_CORES), .IDX_W(OWNER_W)) u_snoop_pick (
    .req    (Com_Bus_Req_snoop & ~owner_oh),
    .ptr    ('0),
    .onehot (snoop_pick_oh),
    .idx    (snoop_idx),
    .valid  (snoop_valid)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  assign timeout_hit = (state != ST_IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_q;

  // A timed-out owner stays blocked until it drops its request for a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      blocked_q <= '0;
    end else begin
      timeout_q <= timeout_hit;
      blocked_q <= (blocked_q & Com_Bus_Req_proc) | (timeout_hit ? owner_oh : '0);
      if (state == ST_IDLE || timeout_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign blocked_q   = '0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      snoop_oh_q <= '0;
    end else begin
      state      <= state_nxt;
      owner_q    <= owner_nxt;
      rr_ptr_q   <= rr_ptr_nxt;
      snoop_oh_q <= snoop_oh_nxt;
    end
  end

  // Release beats a simultaneous snoop; an owner release during a snoop waits for it.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner_q;
    rr_ptr_nxt   = rr_ptr_q;
    snoop_oh_nxt = snoop_oh_q;
    case (state)
      ST_IDLE: begin
        if (proc_valid) begin
          state_nxt = ST_PROC;
          owner_nxt = proc_idx;
        end
      end
      ST_PROC: begin
        if (timeout_hit || !Com_Bus_Req_proc[owner_q]) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = ptr_after_owner;
        end else if (snoop_valid) begin
          state_nxt    = ST_PROC_SNOOP;
          snoop_oh_nxt = snoop_pick_oh;
        end
      end
      ST_PROC_SNOOP: begin
        if (timeout_hit) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = ptr_after_owner;
        end else if (!(|(Com_Bus_Req_snoop & snoop_oh_q))) begin
          state_nxt = ST_PROC;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_busy              = (state != ST_IDLE);
    bus_owner             = bus_busy ? owner_q : '0;
    Com_Bus_Gnt_proc      = bus_busy ? owner_oh : '0;
    Com_Bus_Gnt_snoop     = (state == ST_PROC_SNOOP) ? snoop_oh_q : '0;
    All_Invalidation_done = bus_busy && (&(Invalidation_done | owner_oh));
    Shared                = bus_busy && (|(Shared_local & ~owner_oh));
  end

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Randomized and directed bench for com_bus_arbiter against a cycle-level
// reference model of the arbitration rules.
module tb_com_bus_arbiter;

  localparam int NC = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] req_proc, gnt_proc, req_snoop, gnt_snoop, inv_done, shared_local;
  logic          all_inv, shared, bus_busy, timeout;
  logic [1:0]    bus_owner;

  int num_checks   = 0;
  int num_failures = 0;

  // Reference model: owner/snooper as core numbers, -1 meaning none.
  int            m_owner, m_snoop, m_ptr, m_cnt;
  bit            m_tpulse;
  bit [NC-1:0]   m_blocked;

  com_bus_arbiter #(
    .NUM_CORES(NC), .OWNER_W(2), .TIMEOUT_CYCLES(TO), .CNT_W(9)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .Com_Bus_Req_proc      (req_proc),
    .Com_Bus_Gnt_proc      (gnt_proc),
    .Com_Bus_Req_snoop     (req_snoop),
    .Com_Bus_Gnt_snoop     (gnt_snoop),
    .Invalidation_done     (inv_done),
    .Shared_local          (shared_local),
    .All_Invalidation_done (all_inv),
    .Shared                (shared),
    .bus_busy              (bus_busy),
    .bus_owner             (bus_owner),
    .timeout               (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    num_checks++;
    if (actual != expected) begin
      num_failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_owner   = -1;
    m_snoop   = -1;
    m_ptr     = 0;
    m_cnt     = 0;
    m_tpulse  = 1'b0;
    m_blocked = '0;
  endtask

  task automatic compareModel();
    int eg, es, ea, esh;
    eg  = (m_owner >= 0) ? (1 << m_owner) : 0;
    es  = (m_snoop >= 0) ? (1 << m_snoop) : 0;
    ea  = (m_owner >= 0) ? 1 : 0;
    esh = 0;
    for (int c = 0; c < NC; c++) begin
      if (m_owner >= 0 && c != m_owner) begin
        if (!inv_done[c]) ea = 0;
        if (shared_local[c]) esh = 1;
      end
    end
    checkOutput("gnt_proc", int'(gnt_proc), eg);
    checkOutput("gnt_snoop", int'(gnt_snoop), es);
    checkOutput("bus_busy", int'(bus_busy), (m_owner >= 0) ? 1 : 0);
    checkOutput("bus_owner", int'(bus_owner), (m_owner >= 0) ? m_owner : 0);
    checkOutput("all_inv", int'(all_inv), ea);
    checkOutput("shared", int'(shared), esh);
    checkOutput("timeout", int'(timeout), int'(m_tpulse));
  endtask

  // Advance the model by one rising edge given the inputs sampled there.
  task automatic modelStep(input logic [NC-1:0] rp, input logic [NC-1:0] rs);
    bit timed;
    bit tp;
    int pick;
    int c;
    timed = 1'b0;
    tp    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    timed = (m_owner >= 0) && (m_cnt == TO - 1);
`endif
    pick = -1;
    for (int k = 0; k < NC; k++) begin
      c = (m_ptr + k) % NC;
      if (pick < 0 && rp[c] && !m_blocked[c]) pick = c;
    end
    for (int k = 0; k < NC; k++) if (!rp[k]) m_blocked[k] = 1'b0;
    if (m_owner < 0) begin
      if (pick >= 0) begin
        m_owner = pick;
        m_cnt   = 0;
      end
    end else if (timed) begin
      m_blocked[m_owner] = 1'b1;
      m_ptr   = (m_owner + 1) % NC;
      m_owner = -1;
      m_snoop = -1;
      tp      = 1'b1;
    end else begin
      m_cnt++;
      if (m_snoop >= 0) begin
        if (!rs[m_snoop]) m_snoop = -1;
      end else if (!rp[m_owner]) begin
        m_ptr   = (m_owner + 1) % NC;
        m_owner = -1;
      end else begin
        for (int k = 0; k < NC; k++)
          if (m_snoop < 0 && k != m_owner && rs[k]) m_snoop = k;
      end
    end
    m_tpulse = tp;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic [NC-1:0] rp, input logic [NC-1:0] rs,
                               input logic [NC-1:0] inv, input logic [NC-1:0] sh);
    req_proc     = rp;
    req_snoop    = rs;
    inv_done     = inv;
    shared_local = sh;
    #1;
    compareModel();
    modelStep(rp, rs);
    @(negedge clk);
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_gnt_proc", int'(gnt_proc), 0);
    checkOutput("rst_gnt_snoop", int'(gnt_snoop), 0);
    checkOutput("rst_busy", int'(bus_busy), 0);
    checkOutput("rst_owner", int'(bus_owner), 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          owners[$];
    int          rr_exp[5];
    logic        prev_busy;
    logic [NC-1:0] rp, rs;

    rr_exp = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_proc = '0; req_snoop = '0; inv_done = '0; shared_local = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_gnt_proc", int'(gnt_proc), 0);
    checkOutput("reset_gnt_snoop", int'(gnt_snoop), 0);
    checkOutput("reset_busy", int'(bus_busy), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    rst = 1'b0;

    // Single requester
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("single_gnt", int'(gnt_proc), 4'b0001);
    checkOutput("single_busy", int'(bus_busy), 1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("single_release", int'(gnt_proc), 0);

    // Round-robin fairness with all cores requesting
    doReset();
    prev_busy = 1'b0;
    for (int cyc = 0; cyc < 40 && owners.size() < 5; cyc++) begin
      rp = 4'b1111;
      if (m_owner >= 0 && m_cnt >= 2) rp[m_owner] = 1'b0;
      applyStimulus(rp, 4'b0000, 4'b0000, 4'b0000);
      if (bus_busy && !prev_busy) owners.push_back(int'(bus_owner));
      prev_busy = bus_busy;
    end
    checkOutput("rr_count", owners.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < owners.size()) checkOutput("rr_order", owners[i], rr_exp[i]);

    // Aggregation with core 2 owning
    doReset();
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 4'b0111, 4'b0100);
    checkOutput("agg_inv_missing", int'(all_inv), 0);
    checkOutput("agg_shared_owner", int'(shared), 0);
    applyStimulus(4'b0100, 4'b0000, 4'b1011, 4'b0100);
    checkOutput("agg_inv_all", int'(all_inv), 1);
    applyStimulus(4'b0000, 4'b0000, 4'b1111, 4'b1111);
    checkOutput("agg_idle_inv", int'(all_inv), 0);
    checkOutput("agg_idle_shared", int'(shared), 0);

    // Nested snoop with core 1 owning
    doReset();
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0101, 4'b0000, 4'b0000);
    checkOutput("snoop_first", int'(gnt_snoop), 4'b0001);
    applyStimulus(4'b0010, 4'b0100, 4'b0000, 4'b0000);
    checkOutput("snoop_gap", int'(gnt_snoop), 4'b0000);
    applyStimulus(4'b0010, 4'b0100, 4'b0000, 4'b0000);
    checkOutput("snoop_second", int'(gnt_snoop), 4'b0100);
    checkOutput("snoop_proc_held", int'(gnt_proc), 4'b0010);

    // Reset in the middle of a snoop, then a fresh grant
    doReset();
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("post_rst_gnt", int'(gnt_proc), 4'b0100);

    // Owner release deferred until the snoop completes
    applyStimulus(4'b0100, 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    checkOutput("defer_proc_held", int'(gnt_proc), 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("defer_snoop_done", int'(gnt_snoop), 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("defer_released", int'(gnt_proc), 0);

`ifdef ARB_TIMEOUT_EN
    begin
      int gcount, tcount;
      gcount = 0;
      tcount = 0;
      doReset();
      for (int i = 0; i < 12; i++) begin
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 4'b0000);
        if (gnt_proc == 4'b1000) gcount++;
        if (timeout) tcount++;
      end
      checkOutput("wd_grant_len", gcount, TO);
      checkOutput("wd_pulses", tcount, 1);
      applyStimulus(4'b1001, 4'b0000, 4'b0000, 4'b0000);
      checkOutput("wd_next_owner", int'(gnt_proc), 4'b0001);
    end
`endif

    // Randomized traffic with sticky requests
    doReset();
    rp = '0;
    rs = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (rp[c]) begin
          if ($urandom_range(3) == 0) rp[c] = 1'b0;
        end else if ($urandom_range(2) == 0) rp[c] = 1'b1;
        if (rs[c]) begin
          if ($urandom_range(2) == 0) rs[c] = 1'b0;
        end else if ($urandom_range(4) == 0) rs[c] = 1'b1;
      end
      applyStimulus(rp, rs, NC'($urandom), NC'($urandom));
      if (cyc == 400) doReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
